ps2_scan_rx: RTL and testbench

Parametrised PS/2 keyboard receiver that replaces the fixed 8-bit deserializer. It samples the raw PS/2 clock/data pins in the `Clock` domain and frames full 11-bit packets (start, data, odd parity, stop). It validates parity, stop bit and inter-bit timeout, folds E0/F0 prefixes into extended/break flags, and buffers decoded scan codes in a small FIFO. It sits between the PS/2 pins and the keyboard-consuming logic (display/controller), which pops codes with a read strobe.

---
 rtl/ps2_scan_rx_pkg.sv | 22 ++
 rtl/ps2_scan_rx_sync_fifo.sv | 59 +++++
 rtl/ps2_scan_rx.sv | 185 ++++++++++++++++++
 tb/tb_ps2_scan_rx.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_scan_rx_pkg.sv
// Shared definitions for the PS/2 scan-code receiver.
//   ps2_state_t     : frame FSM states (IDLE / DATA / PARITY / STOP)
//   PS2_PREFIX_EXT  : extended-key prefix byte (E0)
//   PS2_PREFIX_BRK  : key-release prefix byte (F0)
//   ENTRY_*_OFS     : FIFO entry layout {ext, brk, data}; the flag offsets
//                     are relative to DATA_WIDTH (data occupies the low bits).
package ps2_scan_rx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } ps2_state_t;

  localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
  localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;

  localparam int ENTRY_BRK_OFS = 0;
  localparam int ENTRY_EXT_OFS = 1;

endpackage

// File: rtl/ps2_scan_rx_sync_fifo.sv
// Small synchronous first-word-fall-through FIFO.
//   Clock, Reset : system clock, synchronous active-high reset (pointers only)
//   push, din    : write request and entry
//   pop          : read request; ignored while empty
//   full, empty  : occupancy status
//   dout         : head entry, valid whenever empty=0
// A push while full succeeds only if a pop lands in the same cycle.
module ps2_scan_rx_sync_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] dout
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [AW:0]      count;
  logic             pop_ok;
  logic             push_ok;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);
  assign dout    = mem[rptr];

  // Storage is data only and carries no reset.
  always_ff @(posedge Clock) begin
    if (push_ok) mem[wptr] <= din;
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push_ok) wptr <= wptr + 1'b1;
      if (pop_ok)  rptr <= rptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ps2_scan_rx.sv
// PS/2 keyboard receiver: synchronises the raw PS/2 pins, frames 11-bit
// packets (start, DATA_WIDTH data LSB first, odd parity, stop), checks
// parity/stop/inter-bit timeout, folds E0/F0 prefixes into flags and queues
// decoded codes in a FWFT FIFO.
//   Clock, Reset       : system clock, synchronous active-high reset
//   iPS2Clk, iPS2Data  : raw asynchronous PS/2 pins
//   iRead              : pop head entry (ignored when oValid=0)
//   oValid             : FIFO not empty
//   oData              : head scan code
//   oExtended, oBreak  : head entry was preceded by E0 / F0
//   oFrameErr          : one-cycle pulse on parity, stop or timeout error
//   oOverflow          : sticky, a completed code was dropped on a full FIFO
module ps2_scan_rx #(
  parameter int DATA_WIDTH     = 8,
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 12500,
  parameter int DECODE_PREFIX  = 1
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  iPS2Clk,
  input  logic                  iPS2Data,
  input  logic                  iRead,
  output logic                  oValid,
  output logic [DATA_WIDTH-1:0] oData,
  output logic                  oExtended,
  output logic                  oBreak,
  output logic                  oFrameErr,
  output logic                  oOverflow
);

  import ps2_scan_rx_pkg::*;

  localparam int BW      = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam int TW      = $clog2(TIMEOUT_CYCLES + 1);
  localparam int EW      = DATA_WIDTH + 2;
  localparam int EXT_BIT = DATA_WIDTH + ENTRY_EXT_OFS;
  localparam int BRK_BIT = DATA_WIDTH + ENTRY_BRK_OFS;

  // Good frame: odd popcount over data+parity and a high stop bit.
  function automatic logic frame_ok(input logic [DATA_WIDTH-1:0] d,
                                    input logic p, input logic s);
    return (^{d, p}) & s;
  endfunction

  logic clk_p0, clk_p1, clk_p2;
  logic dat_p0, dat_p1;

  ps2_state_t            state;
  logic [BW-1:0]         bitcnt;
  logic [TW-1:0]         tocnt;
  logic [DATA_WIDTH-1:0] shreg;
  logic                  par;
  logic                  ext;
  logic                  brk;
  logic                  frame_err;
  logic                  overflow;

  logic          fall;
  logic          stop_edge;
  logic          good;
  logic          is_ext;
  logic          is_brk;
  logic          push;
  logic [EW-1:0] push_entry;
  logic          fifo_full;
  logic          fifo_empty;
  logic [EW-1:0] fifo_dout;

  // Stage p0/p1: two-flop synchronisers; p2: clock history for edge detect.
  // Reset to 1 because the bus idles high.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      clk_p0 <= 1'b1;
      clk_p1 <= 1'b1;
      clk_p2 <= 1'b1;
      dat_p0 <= 1'b1;
      dat_p1 <= 1'b1;
    end else begin
      clk_p0 <= iPS2Clk;
      clk_p1 <= clk_p0;
      clk_p2 <= clk_p1;
      dat_p0 <= iPS2Data;
      dat_p1 <= dat_p0;
    end
  end

  assign fall      = clk_p2 & ~clk_p1;
  assign stop_edge = fall & (state == ST_STOP);
  assign good      = frame_ok(shreg, par, dat_p1);
  assign is_ext    = (DECODE_PREFIX != 0) && (shreg == DATA_WIDTH'(PS2_PREFIX_EXT));
  assign is_brk    = (DECODE_PREFIX != 0) && (shreg == DATA_WIDTH'(PS2_PREFIX_BRK));
  // The push is combinational so the FIFO write lands on the posedge that
  // ends the stop-bit edge cycle.
  assign push       = stop_edge & good & ~is_ext & ~is_brk;
  assign push_entry = {ext, brk, shreg};

  // Frame assembly, stored bits are data and carry no reset.
  always_ff @(posedge Clock) begin
    if (fall && state == ST_DATA)   shreg[bitcnt] <= dat_p1;
    if (fall && state == ST_PARITY) par <= dat_p1;
  end

  // Frame FSM: moves only on falling PS/2 clock edges, except the timeout.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state     <= ST_IDLE;
      bitcnt    <= '0;
      tocnt     <= '0;
      ext       <= 1'b0;
      brk       <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      if (state == ST_IDLE) begin
        tocnt <= '0;
        if (fall && !dat_p1) begin
          state  <= ST_DATA;
          bitcnt <= '0;
        end
      end else if (fall) begin
        tocnt <= '0;
        case (state)
          ST_DATA: begin
            if (bitcnt == BW'(DATA_WIDTH - 1)) state <= ST_PARITY;
            else bitcnt <= bitcnt + 1'b1;
          end
          ST_PARITY: state <= ST_STOP;
          default: begin
            state <= ST_IDLE;
            if (!good) begin
              frame_err <= 1'b1;
              ext       <= 1'b0;
              brk       <= 1'b0;
            end else if (is_ext) begin
              ext <= 1'b1;
            end else if (is_brk) begin
              brk <= 1'b1;
            end else begin
              ext <= 1'b0;
              brk <= 1'b0;
            end
          end
        endcase
      end else if (tocnt == TW'(TIMEOUT_CYCLES)) begin
        state     <= ST_IDLE;
        tocnt     <= '0;
        frame_err <= 1'b1;
        ext       <= 1'b0;
        brk       <= 1'b0;
      end else begin
        tocnt <= tocnt + 1'b1;
      end
    end
  end

  // A push on a full FIFO is dropped unless the same-cycle pop frees a slot.
  always_ff @(posedge Clock) begin
    if (Reset) overflow <= 1'b0;
    else if (push && fifo_full && !iRead) overflow <= 1'b1;
  end

  ps2_scan_rx_sync_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .Clock (Clock),
    .Reset (Reset),
    .push  (push),
    .din   (push_entry),
    .pop   (iRead),
    .full  (fifo_full),
    .empty (fifo_empty),
    .dout  (fifo_dout)
  );

  // Head outputs read as zero while empty so stale storage never shows.
  assign oValid    = ~fifo_empty;
  assign oData     = fifo_empty ? '0 : fifo_dout[DATA_WIDTH-1:0];
  assign oExtended = ~fifo_empty & fifo_dout[EXT_BIT];
  assign oBreak    = ~fifo_empty & fifo_dout[BRK_BIT];
  assign oFrameErr = frame_err;
  assign oOverflow = overflow;

endmodule

// File: tb/tb_ps2_scan_rx.sv
// Bench for ps2_scan_rx: directed PS/2 frames driven on the pins, a queue
// model of the decoded-code FIFO checked every enabled cycle, and literal
// expectations at key points of each scenario.
module tb_ps2_scan_rx;

  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int TO    = 300;
  localparam int HALF  = 20;

  logic          Clock = 1'b0;
  logic          Reset;
  logic          ps2clk;
  logic          ps2dat;
  logic          rd;
  logic          valid;
  logic [DW-1:0] data;
  logic          extd;
  logic          brkd;
  logic          ferr;
  logic          ovf;

  ps2_scan_rx #(
    .DATA_WIDTH     (DW),
    .FIFO_DEPTH     (DEPTH),
    .TIMEOUT_CYCLES (TO),
    .DECODE_PREFIX  (1)
  ) dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .iPS2Clk   (ps2clk),
    .iPS2Data  (ps2dat),
    .iRead     (rd),
    .oValid    (valid),
    .oData     (data),
    .oExtended (extd),
    .oBreak    (brkd),
    .oFrameErr (ferr),
    .oOverflow (ovf)
  );

  always #5 Clock = ~Clock;

  int checks = 0;
  int errors = 0;

  // Model: queue of {ext, brk, code}, pending prefix flags, sticky overflow,
  // expected number of error pulses.
  logic [9:0] mq[$];
  logic       m_ext, m_brk, m_ovf;
  int         exp_err;
  int         err_seen;
  logic       chk_en;
  logic [9:0] head_e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge Clock) if (ferr) err_seen++;

  always @(negedge Clock) begin
    if (chk_en) begin
      chk("valid", 32'(valid), 32'(mq.size() != 0));
      if (mq.size() != 0) begin
        head_e = mq[0];
        chk("data", 32'(data), 32'(head_e[7:0]));
        chk("ext", 32'(extd), 32'(head_e[9]));
        chk("brk", 32'(brkd), 32'(head_e[8]));
      end else begin
        chk("data_idle", 32'(data), 32'd0);
        chk("ext_idle", 32'(extd), 32'd0);
        chk("brk_idle", 32'(brkd), 32'd0);
      end
      chk("overflow", 32'(ovf), 32'(m_ovf));
    end
  end

  task automatic model_reset();
    mq.delete();
    m_ext = 1'b0;
    m_brk = 1'b0;
    m_ovf = 1'b0;
  endtask

  task automatic model_frame(input logic [7:0] b, input bit ok);
    if (!ok) begin
      exp_err++;
      m_ext = 1'b0;
      m_brk = 1'b0;
    end else if (b == 8'hE0) begin
      m_ext = 1'b1;
    end else if (b == 8'hF0) begin
      m_brk = 1'b1;
    end else begin
      if (mq.size() == DEPTH) m_ovf = 1'b1;
      else mq.push_back({m_ext, m_brk, b});
      m_ext = 1'b0;
      m_brk = 1'b0;
    end
  endtask

  // One full frame; optionally pop so the read lands with the stop-bit push.
  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                            input bit rd_at_stop);
    logic [10:0] bits;
    bits = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < 11; i++) begin
      @(negedge Clock);
      ps2dat = bits[i];
      repeat (HALF / 2) @(negedge Clock);
      if (i == 10) chk_en = 1'b0;
      ps2clk = 1'b0;
      if (i == 10 && rd_at_stop) begin
        @(posedge Clock);
        @(posedge Clock);
        @(negedge Clock);
        rd = 1'b1;
        @(posedge Clock);
        #1 rd = 1'b0;
        void'(mq.pop_front());
      end
      repeat (HALF) @(negedge Clock);
      ps2clk = 1'b1;
      repeat (HALF / 2) @(negedge Clock);
    end
    ps2dat = 1'b1;
    repeat (6) @(negedge Clock);
    model_frame(b, !bad_par && !bad_stop);
    chk_en = 1'b1;
  endtask

  // Start bit plus nd data bits, then the line is left idle-high.
  task automatic send_partial(input logic [7:0] b, input int nd);
    logic [10:0] bits;
    bits = {2'b11, b, 1'b0};
    for (int i = 0; i <= nd; i++) begin
      @(negedge Clock);
      ps2dat = bits[i];
      repeat (HALF / 2) @(negedge Clock);
      ps2clk = 1'b0;
      repeat (HALF) @(negedge Clock);
      ps2clk = 1'b1;
      repeat (HALF / 2) @(negedge Clock);
    end
    ps2dat = 1'b1;
  endtask

  task automatic do_read();
    @(negedge Clock);
    rd = 1'b1;
    @(posedge Clock);
    #1 rd = 1'b0;
    if (mq.size() != 0) void'(mq.pop_front());
  endtask

  task automatic pop_expect(input logic [7:0] exp, input string name);
    @(negedge Clock);
    chk({name, "_valid"}, 32'(valid), 32'd1);
    chk(name, 32'(data), 32'(exp));
    do_read();
  endtask

  initial begin
    #(10 * 90000);
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset = 1'b1; ps2clk = 1'b1; ps2dat = 1'b1; rd = 1'b0;
    chk_en = 1'b0; exp_err = 0; err_seen = 0;
    model_reset();
    repeat (4) @(negedge Clock);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_data", 32'(data), 32'd0);
    chk("rst_ferr", 32'(ferr), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    Reset = 1'b0;
    repeat (2) @(negedge Clock);
    chk_en = 1'b1;

    // Plain make code
    send_frame(8'h1C, 0, 0, 0);
    @(negedge Clock);
    chk("t1_data", 32'(data), 32'h1C);
    chk("t1_flags", 32'({extd, brkd}), 32'd0);
    chk("t1_noerr", 32'(err_seen), 32'd0);
    do_read();
    @(negedge Clock);
    chk("t1_empty", 32'(valid), 32'd0);

    // Extended break, then plain break
    send_frame(8'hE0, 0, 0, 0);
    send_frame(8'hF0, 0, 0, 0);
    send_frame(8'h75, 0, 0, 0);
    @(negedge Clock);
    chk("t2_data", 32'(data), 32'h75);
    chk("t2_flags", 32'({extd, brkd}), 32'b11);
    do_read();
    send_frame(8'hF0, 0, 0, 0);
    send_frame(8'h1C, 0, 0, 0);
    @(negedge Clock);
    chk("t2b_data", 32'(data), 32'h1C);
    chk("t2b_flags", 32'({extd, brkd}), 32'b01);
    do_read();

    // Parity and stop errors
    send_frame(8'h1C, 1, 0, 0);
    chk("t3_err", 32'(err_seen), 32'(exp_err));
    chk("t3_err_lit", 32'(err_seen), 32'd1);
    send_frame(8'h32, 0, 0, 0);
    @(negedge Clock);
    chk("t3_data", 32'(data), 32'h32);
    do_read();
    send_frame(8'hF0, 0, 0, 0);
    send_frame(8'h32, 0, 1, 0);
    chk("t3_stop_err", 32'(err_seen), 32'(exp_err));
    send_frame(8'h29, 0, 0, 0);
    @(negedge Clock);
    chk("t3_brk_cleared", 32'(brkd), 32'd0);
    do_read();

    // Inter-bit timeout
    send_frame(8'hE0, 0, 0, 0);
    send_partial(8'h1C, 3);
    repeat (TO + 100) @(negedge Clock);
    exp_err++;
    m_ext = 1'b0;
    m_brk = 1'b0;
    chk("t4_err", 32'(err_seen), 32'(exp_err));
    send_frame(8'h1C, 0, 0, 0);
    @(negedge Clock);
    chk("t4_data", 32'(data), 32'h1C);
    chk("t4_ext_cleared", 32'(extd), 32'd0);
    do_read();

    // Overflow with no reads
    send_frame(8'h15, 0, 0, 0);
    send_frame(8'h1D, 0, 0, 0);
    send_frame(8'h24, 0, 0, 0);
    send_frame(8'h2D, 0, 0, 0);
    send_frame(8'h2C, 0, 0, 0);
    @(negedge Clock);
    chk("t5_ovf", 32'(ovf), 32'd1);
    pop_expect(8'h15, "t5_pop0");
    pop_expect(8'h1D, "t5_pop1");
    pop_expect(8'h24, "t5_pop2");
    pop_expect(8'h2D, "t5_pop3");
    @(negedge Clock);
    chk("t5_empty", 32'(valid), 32'd0);
    chk("t5_ovf_sticky", 32'(ovf), 32'd1);

    // Reset in the middle of a frame with entries queued
    send_frame(8'h15, 0, 0, 0);
    send_frame(8'hF0, 0, 0, 0);
    send_partial(8'h1D, 4);
    @(negedge Clock);
    chk_en = 1'b0;
    Reset = 1'b1;
    repeat (3) @(negedge Clock);
    Reset = 1'b0;
    model_reset();
    @(negedge Clock);
    chk("t6_valid", 32'(valid), 32'd0);
    chk("t6_data", 32'(data), 32'd0);
    chk("t6_flags", 32'({extd, brkd, ferr}), 32'd0);
    chk("t6_ovf", 32'(ovf), 32'd0);
    chk_en = 1'b1;
    send_frame(8'h1C, 0, 0, 0);
    @(negedge Clock);
    chk("t6_data_after", 32'(data), 32'h1C);
    chk("t6_brk_after", 32'(brkd), 32'd0);
    do_read();

    // Full FIFO, last push coincides with a pop
    send_frame(8'h16, 0, 0, 0);
    send_frame(8'h1E, 0, 0, 0);
    send_frame(8'h26, 0, 0, 0);
    send_frame(8'h25, 0, 0, 0);
    send_frame(8'h2E, 0, 0, 1);
    @(negedge Clock);
    chk("t7_ovf", 32'(ovf), 32'd0);
    pop_expect(8'h1E, "t7_pop0");
    pop_expect(8'h26, "t7_pop1");
    pop_expect(8'h25, "t7_pop2");
    pop_expect(8'h2E, "t7_pop3");
    @(negedge Clock);
    chk("t7_empty", 32'(valid), 32'd0);
    chk("final_err_count", 32'(err_seen), 32'(exp_err));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
